// File: rtl/seq_det_sched.sv
// Round-robin front end sharing one bit-serial overlapping pattern detector
// among N_CH channels; reports channel and match count per packet.
module seq_det_sched #(
    parameter int                N_CH    = 4,
    parameter int                PKT_LEN = 8,
    parameter int                PATT_W  = 4,
    parameter logic [PATT_W-1:0] PATT    = 4'b1110,
    parameter int                CW      = $clog2(PKT_LEN + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_CH-1:0]            req,
    input  logic [N_CH*PKT_LEN-1:0]    ch_data,
    output logic [N_CH-1:0]            gnt,
    output logic                       busy,
    output logic                       det_valid,
    output logic [$clog2(N_CH)-1:0]    det_ch,
    output logic [CW-1:0]              det_count,
    output logic                       det_hit
);
    localparam int             CHW  = $clog2(N_CH);
    localparam logic [CW-1:0]  LEN  = CW'(PKT_LEN);
    localparam logic [CW-1:0]  FILL = CW'(PATT_W - 1);
    localparam logic [CHW-1:0] LAST = CHW'(N_CH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, REPORT} state_t;

    state_t              state;
    logic [CHW-1:0]      ptr;
    logic [CHW-1:0]      sel;
    logic [CHW-1:0]      cur;
    logic                found;
    logic [PKT_LEN-1:0]  sreg;
    logic [PATT_W-1:0]   hist;
    logic [PATT_W-1:0]   hist_nx;
    logic [CW-1:0]       nbits;
    logic [CW-1:0]       cnt;
    logic                match;

    // First requester at or above ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        sel   = ptr;
        for (int i = 0; i < N_CH; i++) begin
            if (!found && req[(int'(ptr) + i) % N_CH]) begin
                found = 1'b1;
                sel   = CHW'((int'(ptr) + i) % N_CH);
            end
        end
    end

    assign hist_nx = {hist[PATT_W-2:0], sreg[PKT_LEN-1]};
    // nbits counts bits already shifted, so this shift is bit nbits+1.
    assign match   = (nbits >= FILL) && (hist_nx == PATT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            cur       <= '0;
            sreg      <= '0;
            hist      <= '0;
            nbits     <= '0;
            cnt       <= '0;
            gnt       <= '0;
            busy      <= 1'b0;
            det_valid <= 1'b0;
            det_ch    <= '0;
            det_count <= '0;
            det_hit   <= 1'b0;
        end else begin
            gnt       <= '0;
            det_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt   <= N_CH'(1) << sel;
                        sreg  <= ch_data[int'(sel)*PKT_LEN +: PKT_LEN];
                        hist  <= '0;
                        nbits <= '0;
                        cnt   <= '0;
                        cur   <= sel;
                        ptr   <= (sel == LAST) ? '0 : sel + 1'b1;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // The grant cycle is spent here too; the extra cycle
                    // after the last shift hands off to REPORT.
                    if (nbits != LEN) begin
                        sreg  <= sreg << 1;
                        hist  <= hist_nx;
                        nbits <= nbits + 1'b1;
                        if (match) cnt <= cnt + 1'b1;
                    end else begin
                        det_valid <= 1'b1;
                        det_ch    <= cur;
                        det_count <= cnt;
                        det_hit   <= (cnt != '0);
                        state     <= REPORT;
                    end
                end
                REPORT: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
